// File: rtl/hdmi_frame_timing_pkg.sv
// Shared HDMI definitions: TMDS control-token words, their sync decode and the
// frame-timing state encodings.
package hdmi_frame_timing_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;  // {vsync,hsync} = 00
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0ab;  // {vsync,hsync} = 01
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;  // {vsync,hsync} = 10
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2ab;  // {vsync,hsync} = 11

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic vsync;
        logic hsync;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [9:0] word);
        ctrl_t c;
        c = '0;
        case (word)
            TMDS_CTRL_00: c = '{valid: 1'b1, vsync: 1'b0, hsync: 1'b0};
            TMDS_CTRL_01: c = '{valid: 1'b1, vsync: 1'b0, hsync: 1'b1};
            TMDS_CTRL_10: c = '{valid: 1'b1, vsync: 1'b1, hsync: 1'b0};
            TMDS_CTRL_11: c = '{valid: 1'b1, vsync: 1'b1, hsync: 1'b1};
            default:      c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hdmi_frame_timing_tmdstoken.sv
// TMDS control-token decoder: registers {vsync,hsync} from the four control
// tokens and holds them across pixel data.
module tmdstoken
    import hdmi_frame_timing_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_word,
    output logic       o_hsync,
    output logic       o_vsync
);

    ctrl_t ctrl;

    assign ctrl = decode_ctrl(i_word);

    // NOTE: the hold on non-token words lives in a clocked block with <=, so it
    // is a flop enable, not a latch.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
        end else if (ctrl.valid) begin
            o_hsync <= ctrl.hsync;
            o_vsync <= ctrl.vsync;
        end
    end

endmodule

// File: rtl/hdmi_frame_timing.sv
// Measures HDMI frame/line timing from the blue TMDS channel and reports
// clocks per frame, clocks per line and lines per frame, with a lock flag.
module hdmi_frame_timing
    import hdmi_frame_timing_pkg::*;
#(
    parameter int CLKBITS  = 30,
    parameter int LINEBITS = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [9:0]          i_hdmi_b,
    output logic [CLKBITS-1:0]  o_frame_clks,
    output logic [LINEBITS-1:0] o_line_clks,
    output logic [LINEBITS-1:0] o_lines,
    output logic                o_stb,
    output logic                o_locked
);

    logic                hsync, vsync;
    logic                last_hsync, last_vsync;
    logic                line_edge, frame_edge;
    logic                frame_sat, line_sat;
    logic [CLKBITS-1:0]  frame_count;
    logic [LINEBITS-1:0] line_count;
    logic [LINEBITS-1:0] line_tally;
    state_t              state;

    tmdstoken u_tmdstoken (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_word  (i_hdmi_b),
        .o_hsync (hsync),
        .o_vsync (vsync)
    );

    assign line_edge  = hsync && !last_hsync;
    assign frame_edge = vsync && !last_vsync;
    assign frame_sat  = &frame_count;
    assign line_sat   = &line_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_hsync <= 1'b0;
            last_vsync <= 1'b0;
        end else begin
            last_hsync <= hsync;
            last_vsync <= vsync;
        end
    end

    // Counters hold the elapsed clocks minus one at the moment the next edge arrives.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            frame_count <= '0;
            line_count  <= '0;
            line_tally  <= '0;
        end else begin
            if (frame_edge)
                frame_count <= '0;
            else if (!frame_sat)
                frame_count <= frame_count + 1'b1;

            if (line_edge)
                line_count <= '0;
            else if (!line_sat)
                line_count <= line_count + 1'b1;

            // A line starting on the frame boundary belongs to the new frame.
            if (frame_edge)
                line_tally <= line_edge ? LINEBITS'(1) : '0;
            else if (line_edge && !(&line_tally))
                line_tally <= line_tally + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_line_clks <= '0;
        else if (line_edge && !line_sat)
            o_line_clks <= line_count;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= SEARCH;
            o_frame_clks <= '0;
            o_lines      <= '0;
            o_stb        <= 1'b0;
            o_locked     <= 1'b0;
        end else begin
            o_stb <= 1'b0;
            case (state)
                SEARCH: begin
                    o_locked <= 1'b0;
                    if (frame_edge)
                        state <= MEASURE;
                end
                MEASURE, TRACK: begin
                    if (frame_sat) begin
                        state    <= SEARCH;
                        o_locked <= 1'b0;
                    end else if (frame_edge) begin
                        state        <= TRACK;
                        o_frame_clks <= frame_count;
                        o_lines      <= line_tally;
                        o_stb        <= 1'b1;
                        o_locked     <= (state == TRACK) && (frame_count == o_frame_clks);
                    end
                end
                default: begin
                    state    <= SEARCH;
                    o_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_frame_timing.sv
// Directed bench for hdmi_frame_timing on a scaled-down raster (40 clocks x 21
// lines, 4-clock hsync, 2-line vsync) with an 11-bit frame counter.
module tb_hdmi_frame_timing;

    localparam int CLKBITS     = 11;
    localparam int LINEBITS    = 16;
    localparam int LINE_CLKS   = 40;
    localparam int HSYNC_CLKS  = 4;
    localparam int BLANK_END   = 10;
    localparam int VSYNC_LINES = 2;
    localparam int FRAME_LINES = 21;
    localparam int FRAME_CLKS  = LINE_CLKS * FRAME_LINES;

    logic                i_clk;
    logic                i_reset;
    logic [9:0]          i_hdmi_b;
    logic [CLKBITS-1:0]  o_frame_clks;
    logic [LINEBITS-1:0] o_line_clks;
    logic [LINEBITS-1:0] o_lines;
    logic                o_stb;
    logic                o_locked;

    hdmi_frame_timing #(
        .CLKBITS  (CLKBITS),
        .LINEBITS (LINEBITS)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_hdmi_b     (i_hdmi_b),
        .o_frame_clks (o_frame_clks),
        .o_line_clks  (o_line_clks),
        .o_lines      (o_lines),
        .o_stb        (o_stb),
        .o_locked     (o_locked)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   stb_count   = 0;
    int   stb_wide    = 0;
    int   stb_base    = 0;
    logic stb_prev    = 1'b0;

    always begin
        @(posedge i_clk);
        #1;
        if (o_stb === 1'b1) begin
            stb_count++;
            if (stb_prev) stb_wide++;
        end
        stb_prev = (o_stb === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] data_word();
        logic [9:0] w;
        do
            w = 10'($urandom);
        while (w inside {10'h354, 10'h0ab, 10'h154, 10'h2ab});
        return w;
    endfunction

    task automatic send_word(input logic [9:0] w);
        @(negedge i_clk);
        i_hdmi_b = w;
    endtask

    // Vsync lines carry one data word between 10'h154 tokens; vsync must hold.
    task automatic send_line(input bit vs);
        for (int c = 0; c < LINE_CLKS; c++) begin
            if (c < HSYNC_CLKS)
                send_word(vs ? 10'h2ab : 10'h0ab);
            else if (vs)
                send_word((c == HSYNC_CLKS + 1) ? data_word() : 10'h154);
            else if (c < BLANK_END)
                send_word(10'h354);
            else
                send_word(data_word());
        end
    endtask

    task automatic send_lines(input int first, input int last);
        for (int l = first; l < last; l++)
            send_line(l < VSYNC_LINES);
    endtask

    task automatic send_frame(input int nlines);
        send_lines(0, nlines);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_frame_clks"}, 32'(o_frame_clks), 0);
        check({tag, "_line_clks"},  32'(o_line_clks),  0);
        check({tag, "_lines"},      32'(o_lines),      0);
        check({tag, "_locked"},     32'(o_locked),     0);
        check({tag, "_stb"},        32'(o_stb),        0);
    endtask

    initial begin
        i_reset  = 1'b1;
        i_hdmi_b = 10'h000;
        repeat (3) @(negedge i_clk);
        check_zero("reset");
        i_reset = 1'b0;

        // Three frames: first boundary only arms, second and third report.
        send_frame(FRAME_LINES);
        check("search_no_stb", 32'(stb_count), 0);
        send_frame(FRAME_LINES);
        check("measure_stb", 32'(stb_count), 1);
        check("measure_frame_clks", 32'(o_frame_clks), FRAME_CLKS - 1);
        check("measure_not_locked", 32'(o_locked), 0);
        send_frame(FRAME_LINES);
        check("track_stb", 32'(stb_count), 2);
        check("track_frame_clks", 32'(o_frame_clks), FRAME_CLKS - 1);
        check("track_line_clks", 32'(o_line_clks), LINE_CLKS - 1);
        check("coincident_tally_lines", 32'(o_lines), FRAME_LINES);
        check("track_locked", 32'(o_locked), 1);

        // One frame lengthened by a line while locked.
        send_frame(FRAME_LINES + 1);
        check("vsync_hold_stb", 32'(stb_count), 3);
        check("long_prev_locked", 32'(o_locked), 1);
        send_frame(FRAME_LINES);
        check("long_frame_clks", 32'(o_frame_clks), FRAME_CLKS + LINE_CLKS - 1);
        check("long_lines", 32'(o_lines), FRAME_LINES + 1);
        check("long_unlocked", 32'(o_locked), 0);
        send_frame(FRAME_LINES);
        check("relock1_frame_clks", 32'(o_frame_clks), FRAME_CLKS - 1);
        check("relock1_unlocked", 32'(o_locked), 0);
        send_frame(FRAME_LINES);
        check("relock2_locked", 32'(o_locked), 1);
        check("relock2_lines", 32'(o_lines), FRAME_LINES);

        // Data only until the 11-bit frame counter saturates.
        stb_base = stb_count;
        for (int i = 0; i < 2100; i++)
            send_word(data_word());
        check("sat_unlocked", 32'(o_locked), 0);
        check("sat_hold_frame_clks", 32'(o_frame_clks), FRAME_CLKS - 1);
        check("sat_hold_line_clks", 32'(o_line_clks), LINE_CLKS - 1);
        check("sat_hold_lines", 32'(o_lines), FRAME_LINES);
        check("sat_no_stb", 32'(stb_count), 32'(stb_base));
        send_frame(FRAME_LINES);
        check("sat_search_no_stb", 32'(stb_count), 32'(stb_base));
        send_frame(FRAME_LINES);
        check("sat_measure_stb", 32'(stb_count), 32'(stb_base + 1));
        check("sat_measure_unlocked", 32'(o_locked), 0);
        send_frame(FRAME_LINES);
        check("sat_relocked", 32'(o_locked), 1);

        // Reset in the middle of an active line region while tracking.
        send_lines(0, 10);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        check_zero("midreset");
        i_reset  = 1'b0;
        stb_base = stb_count;
        send_lines(10, FRAME_LINES);
        send_frame(FRAME_LINES);
        check("midreset_first_boundary_no_stb", 32'(stb_count), 32'(stb_base));
        send_frame(FRAME_LINES);
        check("midreset_second_boundary_stb", 32'(stb_count), 32'(stb_base + 1));
        check("midreset_frame_clks", 32'(o_frame_clks), FRAME_CLKS - 1);

        check("stb_single_cycle", 32'(stb_wide), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
